// File: rtl/uart_port_master_if.sv
// Bundle of UART FIFO and port bus signals for uart_port_master.
// Port bus and FIFO signals between uart_port_master and its environment.
interface uart_port_master_if;
  logic [7:0] rx_data;
  logic       rx_data_present;
  logic       rx_read;
  logic [7:0] tx_data;
  logic       tx_write;
  logic       tx_full;
  logic [7:0] port_id;
  logic [7:0] out_port;
  logic       write_strobe;
  logic       read_strobe;
  logic [7:0] in_port;
  logic       busy;
  logic       timeout;

  modport master (
    input  rx_data, rx_data_present, tx_full, in_port,
    output rx_read, tx_data, tx_write, port_id, out_port,
    output write_strobe, read_strobe, busy, timeout
  );

  modport slave (
    output rx_data, rx_data_present, tx_full, in_port,
    input  rx_read, tx_data, tx_write, port_id, out_port,
    input  write_strobe, read_strobe, busy, timeout
  );
endinterface

// File: rtl/uart_port_master.sv
// UART command master for an 8-bit port bus (W addr data / R addr).
// Optional write ACK byte: define UART_PORT_MASTER_WRACK_EN.
module uart_port_master #(
  parameter int READ_LATENCY   = 1,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int TIMEOUT_W      = 20
) (
  input logic                 clk,
  input logic                 reset_n,
  uart_port_master_if.master  bus
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] GET_ADDR  = 3'd1;
  localparam logic [2:0] GET_DATA  = 3'd2;
  localparam logic [2:0] WR_STROBE = 3'd3;
  localparam logic [2:0] RD_STROBE = 3'd4;
  localparam logic [2:0] RD_WAIT   = 3'd5;
  localparam logic [2:0] SEND      = 3'd6;

  localparam logic [7:0] CMD_W = 8'h57;
  localparam logic [7:0] CMD_R = 8'h52;
  localparam logic [7:0] NAK   = 8'h15;

  localparam logic [2:0] RD_LAST = 3'(READ_LATENCY - 1);
  localparam logic [TIMEOUT_W-1:0] TO_LAST =
    TIMEOUT_W'(TIMEOUT_CYCLES - 1);
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

  logic [2:0]           state;
  logic [2:0]           nxt;
  logic                 armed;
  logic                 is_wr;
  logic [TIMEOUT_W-1:0] tcnt;
  logic [2:0]           wcnt;
  logic                 intake;
  logic                 gathering;
  logic                 take;
  logic                 expire;
  logic                 known;

  always_comb begin
    intake    = (state == IDLE) || (state == GET_ADDR)
             || (state == GET_DATA);
    gathering = (state == GET_ADDR) || (state == GET_DATA);
    take      = armed && intake && bus.rx_data_present;
    // A byte arriving in the expiry cycle wins over the timeout
    expire    = TO_EN && gathering && !bus.rx_data_present
             && (tcnt == TO_LAST);
    known     = (bus.rx_data == CMD_W) || (bus.rx_data == CMD_R);
  end

  assign bus.rx_read      = take;
  assign bus.tx_write     = (state == SEND) && !bus.tx_full;
  assign bus.write_strobe = (state == WR_STROBE);
  assign bus.read_strobe  = (state == RD_STROBE);

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:      if (take) nxt = known ? GET_ADDR : SEND;
      GET_ADDR: begin
        if (take)        nxt = is_wr ? GET_DATA : RD_STROBE;
        else if (expire) nxt = IDLE;
      end
      GET_DATA: begin
        if (take)        nxt = WR_STROBE;
        else if (expire) nxt = IDLE;
      end
`ifdef UART_PORT_MASTER_WRACK_EN
      WR_STROBE: nxt = SEND;
`else
      WR_STROBE: nxt = IDLE;
`endif
      RD_STROBE: nxt = RD_WAIT;
      RD_WAIT:   if (wcnt == RD_LAST) nxt = SEND;
      SEND:      if (bus.tx_write) nxt = IDLE;
      default:   nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      armed        <= 1'b0;
      is_wr        <= 1'b0;
      tcnt         <= '0;
      wcnt         <= '0;
      bus.port_id  <= '0;
      bus.out_port <= '0;
      bus.tx_data  <= '0;
      bus.busy     <= 1'b0;
      bus.timeout  <= 1'b0;
    end else begin
      armed       <= 1'b1;
      state       <= nxt;
      bus.busy    <= (nxt != IDLE);
      bus.timeout <= expire;
      if (take || nxt == IDLE)
        tcnt <= '0;
      else if (gathering)
        tcnt <= tcnt + 1'b1;
      unique case (state)
        IDLE: if (take) begin
          is_wr <= (bus.rx_data == CMD_W);
          if (!known) bus.tx_data <= NAK;
        end
        GET_ADDR: if (take) bus.port_id <= bus.rx_data;
        GET_DATA: if (take) bus.out_port <= bus.rx_data;
`ifdef UART_PORT_MASTER_WRACK_EN
        WR_STROBE: bus.tx_data <= 8'h06;
`endif
        RD_STROBE: wcnt <= '0;
        RD_WAIT: begin
          wcnt <= wcnt + 3'd1;
          if (wcnt == RD_LAST) bus.tx_data <= bus.in_port;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_port_master.sv
// Bench for uart_port_master: command table plus backpressure,
// timeout and reset sequences, checked through event queues.
module tb_uart_port_master;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  uart_port_master_if u_if();

  uart_port_master #(
    .READ_LATENCY(1),
    .TIMEOUT_CYCLES(100),
    .TIMEOUT_W(20)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(u_if)
  );

`ifdef UART_PORT_MASTER_WRACK_EN
  localparam bit WRACK = 1'b1;
`else
  localparam bit WRACK = 1'b0;
`endif

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [7:0] port;
    logic [7:0] data;
  } wr_t;

  wr_t        wr_q[$];
  logic [7:0] rd_q[$];
  logic [7:0] tx_q[$];
  int         pops = 0;
  int         touts = 0;

  // Peripheral model: read data valid only in the cycle after the strobe
  logic       rs_d;
  logic [7:0] rd_val = 8'h00;
  always @(posedge clk or negedge reset_n)
    if (!reset_n) rs_d <= 1'b0;
    else          rs_d <= u_if.read_strobe;
  assign u_if.in_port = rs_d ? rd_val : 8'hEE;

  always @(negedge clk) if (reset_n) begin
    if (u_if.rx_read) pops++;
    if (u_if.timeout) touts++;
    if (u_if.write_strobe && u_if.read_strobe)
      check("strobe_excl", 1, 0);
    if (u_if.write_strobe) begin
      if (wr_q.size() == 0) check("unexp_wr", 1, 0);
      else begin
        wr_t e;
        e = wr_q.pop_front();
        check("wr_port", u_if.port_id, e.port);
        check("wr_data", u_if.out_port, e.data);
      end
    end
    if (u_if.read_strobe) begin
      if (rd_q.size() == 0) check("unexp_rd", 1, 0);
      else check("rd_port", u_if.port_id, rd_q.pop_front());
    end
    if (u_if.tx_write) begin
      if (tx_q.size() == 0) check("unexp_tx", 1, 0);
      else check("tx_data", u_if.tx_data, tx_q.pop_front());
    end
  end

  typedef struct {
    int         n;
    logic [7:0] b0, b1, b2, din;
    int         kind;
    logic [7:0] port, data, tx;
    bit         has_tx;
  } vec_t;

  vec_t vt[7];

  task automatic send_byte(input logic [7:0] b);
    int k = 0;
    u_if.rx_data = b;
    u_if.rx_data_present = 1'b1;
    @(negedge clk);
    while (!u_if.rx_read && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (k >= 20) check("rx_read_wait", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (u_if.busy && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= 200) check("idle_wait", 0, 1);
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int p0 = pops;
    if (v.kind == 1) wr_q.push_back({v.port, v.data});
    if (v.kind == 2) begin
      rd_q.push_back(v.port);
      rd_val = v.din;
    end
    if (v.has_tx) tx_q.push_back(v.tx);
    send_byte(v.b0);
    if (v.n > 1) send_byte(v.b1);
    if (v.n > 2) send_byte(v.b2);
    u_if.rx_data_present = 1'b0;
    wait_idle();
    check({tag, "_pops"}, pops - p0, v.n);
    check({tag, "_drain"}, wr_q.size() + rd_q.size() + tx_q.size(), 0);
    check({tag, "_busy"}, {31'd0, u_if.busy}, 0);
  endtask

  function automatic logic [29:0] outs();
    return {u_if.rx_read, u_if.tx_write, u_if.write_strobe,
            u_if.read_strobe, u_if.busy, u_if.timeout,
            u_if.port_id, u_if.out_port, u_if.tx_data};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    int k;
    int bad;
    vt[0] = '{3, 8'h57, 8'h21, 8'hA5, 8'h00, 1, 8'h21, 8'hA5, 8'h06, WRACK};
    vt[1] = '{2, 8'h52, 8'h10, 8'h00, 8'h3C, 2, 8'h10, 8'h00, 8'h3C, 1'b1};
    vt[2] = '{1, 8'h41, 8'h00, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h15, 1'b1};
    vt[3] = '{3, 8'h57, 8'hFF, 8'h00, 8'h00, 1, 8'hFF, 8'h00, 8'h06, WRACK};
    vt[4] = '{2, 8'h52, 8'h00, 8'h00, 8'hC3, 2, 8'h00, 8'h00, 8'hC3, 1'b1};
    vt[5] = '{1, 8'h00, 8'h00, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h15, 1'b1};
    vt[6] = '{3, 8'h57, 8'h52, 8'h57, 8'h00, 1, 8'h52, 8'h57, 8'h06, WRACK};

    u_if.rx_data = 8'h57;
    u_if.rx_data_present = 1'b1;
    u_if.tx_full = 1'b0;
    #12;
    check("reset_outs", {2'b0, outs()}, 0);
    u_if.rx_data_present = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) run_vec(vt[i], $sformatf("vec%0d", i));

    // Read held off by a full transmit FIFO
    u_if.tx_full = 1'b1;
    rd_q.push_back(8'h20);
    rd_val = 8'h5A;
    tx_q.push_back(8'h5A);
    send_byte(8'h52);
    send_byte(8'h20);
    u_if.rx_data_present = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      if (u_if.tx_write || !u_if.busy) bad++;
      @(posedge clk); #1;
    end
    check("bp_hold", bad, 0);
    check("bp_pending", tx_q.size(), 1);
    u_if.tx_full = 1'b0;
    wait_idle();
    check("bp_drain", tx_q.size() + rd_q.size(), 0);
    check("bp_busy", {31'd0, u_if.busy}, 0);

    // Abandoned write command expires after the idle window
    send_byte(8'h57);
    u_if.rx_data_present = 1'b0;
    k = 0;
    while (!u_if.timeout && k < 300) begin
      @(posedge clk); #1;
      k++;
    end
    check("to_delay", k, 100);
    check("to_busy", {31'd0, u_if.busy}, 0);
    @(posedge clk); #1;
    check("to_pulse", {31'd0, u_if.timeout}, 0);
    check("to_count", touts, 1);
    run_vec(vt[1], "after_to");

    // Reset dropped in the middle of a write
    send_byte(8'h57);
    send_byte(8'h33);
    u_if.rx_data_present = 1'b1;
    u_if.rx_data = 8'h77;
    check("mid_state", {31'd0, u_if.busy}, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_reset_outs", {2'b0, outs()}, 0);
    @(posedge clk); #1;
    u_if.rx_data_present = 1'b0;
    reset_n = 1'b1;
    @(posedge clk); #1;
    run_vec('{3, 8'h57, 8'h44, 8'h99, 8'h00, 1, 8'h44, 8'h99, 8'h06,
              WRACK}, "after_rst");
    check("no_extra_to", touts, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
